// File: rtl/sd_sector_responder_if.sv
// sd_sector_responder_if
//   Bundles the requester-side block transfer signals of the sector responder.
//   master : the requester (host core) - drives lba / rd / wr / buffer write data / wp
//   slave  : the responder              - drives ack, buffer address/data/strobe, image status
interface sd_sector_responder_if;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd;
    logic [1:0]  sd_wr;
    logic [7:0]  sd_buff_din;
    logic [1:0]  wp;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [1:0]  img_mounted;
    logic [1:0]  img_readonly;
    logic [63:0] img_size;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, wp,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               img_mounted, img_readonly, img_size
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, wp,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               img_mounted, img_readonly, img_size
    );
endinterface

// File: rtl/sd_sector_responder.sv
// sd_sector_responder
//   Emulates the SD-card side of a sector-based block interface for two drive
//   images held in an internal byte RAM. After reset it announces both images
//   (one-cycle img_mounted pulse), then services one 512-byte read or write
//   request at a time.
// Ports
//   clk_sys  : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of sd_sector_responder_if (request, buffer, status)
// Parameters
//   SECTORS  : sectors per drive image (power of two; RAM is indexed {drive, lba, byte})
//   ACK_DLY  : cycles from request capture to sd_ack rise (>= 1)
module sd_sector_responder #(
    parameter int SECTORS = 8,
    parameter int ACK_DLY = 2
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    sd_sector_responder_if.slave   bus
);
    localparam int LBA_W = (SECTORS > 1) ? $clog2(SECTORS) : 1;
    localparam int AW    = 1 + LBA_W + 9;
    localparam int DLY_W = $clog2(ACK_DLY + 1);

    typedef enum logic [2:0] {MOUNT, IDLE, DELAY, READ, WRITE, DONE} state_t;

    state_t             state_q, state_d;
    logic               drv_q, drv_d;        // serviced drive
    logic               wdir_q, wdir_d;      // 1 = write transfer
    logic [LBA_W-1:0]   lba_q, lba_d;
    logic               oor_q, oor_d;        // captured lba beyond the image
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [8:0]         cnt_q, cnt_d;
    logic               phase_q, phase_d;    // second cycle of a byte slot
    logic               last_q, last_d;      // byte 511 already strobed (read)
    logic               ack_q, ack_d;
    logic [8:0]         addr_q, addr_d;
    logic [7:0]         dout_q, dout_d;
    logic               bwr_q, bwr_d;
    logic [1:0]         mnt_q, mnt_d;
    logic [1:0]         ro_q, ro_d;

    logic [7:0]         mem [0:(1<<AW)-1];
    logic [7:0]         ram_rd_q;
    logic [AW-1:0]      ram_addr;
    logic               ram_we;

    assign ram_addr = {drv_q, lba_q, cnt_q};

    always_comb begin
        state_d = state_q;
        drv_d   = drv_q;
        wdir_d  = wdir_q;
        lba_d   = lba_q;
        oor_d   = oor_q;
        dly_d   = dly_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        last_d  = last_q;
        ack_d   = ack_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        bwr_d   = 1'b0;
        mnt_d   = 2'b00;
        ro_d    = bus.wp;
        ram_we  = 1'b0;

        case (state_q)
            MOUNT: begin
                mnt_d   = 2'b11;
                state_d = IDLE;
            end
            IDLE: begin
                if (|(bus.sd_rd | bus.sd_wr)) begin
                    lba_d   = bus.sd_lba[LBA_W-1:0];
                    oor_d   = (bus.sd_lba >= 32'(SECTORS));
                    dly_d   = DLY_W'(ACK_DLY - 1);
                    state_d = DELAY;
                    if (bus.sd_rd[0]) begin
                        drv_d = 1'b0; wdir_d = 1'b0;
                    end else if (bus.sd_rd[1]) begin
                        drv_d = 1'b1; wdir_d = 1'b0;
                    end else if (bus.sd_wr[0]) begin
                        drv_d = 1'b0; wdir_d = 1'b1;
                    end else begin
                        drv_d = 1'b1; wdir_d = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (dly_q == '0) begin
                    ack_d   = 1'b1;
                    cnt_d   = 9'd0;
                    phase_d = 1'b0;
                    last_d  = 1'b0;
                    if (wdir_q) begin
                        addr_d  = 9'd0;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            READ: begin
                // phase 0 launches the RAM read, phase 1 presents the byte
                if (!phase_q) begin
                    if (last_q) begin
                        ack_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    bwr_d   = 1'b1;
                    addr_d  = cnt_q;
                    dout_d  = oor_q ? 8'hE5 : ram_rd_q;
                    phase_d = 1'b0;
                    if (cnt_q == 9'd511) last_d = 1'b1;
                    else                 cnt_d  = cnt_q + 9'd1;
                end
            end
            WRITE: begin
                // address held two cycles; requester data is valid on the second
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    ram_we  = !oor_q && !bus.wp[drv_q];
                    phase_d = 1'b0;
                    if (cnt_q == 9'd511) begin
                        ack_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        cnt_d  = cnt_q + 9'd1;
                        addr_d = cnt_q + 9'd1;
                    end
                end
            end
            DONE: begin
                // wait for the serviced request to drop so a held request is not re-run
                if (!(wdir_q ? bus.sd_wr[drv_q] : bus.sd_rd[drv_q])) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MOUNT;
            drv_q   <= 1'b0;
            wdir_q  <= 1'b0;
            lba_q   <= '0;
            oor_q   <= 1'b0;
            dly_q   <= '0;
            cnt_q   <= 9'd0;
            phase_q <= 1'b0;
            last_q  <= 1'b0;
            ack_q   <= 1'b0;
            addr_q  <= 9'd0;
            dout_q  <= 8'd0;
            bwr_q   <= 1'b0;
            mnt_q   <= 2'b00;
            ro_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            drv_q   <= drv_d;
            wdir_q  <= wdir_d;
            lba_q   <= lba_d;
            oor_q   <= oor_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            bwr_q   <= bwr_d;
            mnt_q   <= mnt_d;
            ro_q    <= ro_d;
        end
    end

    // Image storage: no reset so contents survive reset_n
    always_ff @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= bus.sd_buff_din;
        ram_rd_q <= mem[ram_addr];
    end

    assign bus.sd_ack       = ack_q;
    assign bus.sd_buff_addr = addr_q;
    assign bus.sd_buff_dout = dout_q;
    assign bus.sd_buff_wr   = bwr_q;
    assign bus.img_mounted  = mnt_q;
    assign bus.img_readonly = ro_q;
    assign bus.img_size     = 64'(SECTORS) * 64'd512;
endmodule

// File: doc/sd_sector_responder.md
SD_SECTOR_RESPONDER -- requirements
Module: sd_sector_responder

Interface
REQ-001 SHALL have parameter SECTORS, default 8, meaning sectors per drive image (two drive images).
REQ-002 SHALL have parameter ACK_DLY, default 2, meaning the number of cycles from request capture to sd_ack rise (minimum 1).
REQ-003 SHALL have port clk_sys, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sd_lba, input, 32 bits: sector number from the requester.
REQ-006 SHALL have port sd_rd, input, 2 bits: per-drive read request.
REQ-007 SHALL have port sd_wr, input, 2 bits: per-drive write request.
REQ-008 SHALL have port sd_buff_din, input, 8 bits: requester buffer byte for writes.
REQ-009 SHALL have port wp, input, 2 bits: per-drive write protect.
REQ-010 SHALL have port sd_ack, output, 1 bit: transfer in progress.
REQ-011 SHALL have port sd_buff_addr, output, 9 bits: byte index within the sector.
REQ-012 SHALL have port sd_buff_dout, output, 8 bits: read data to the requester.
REQ-013 SHALL have port sd_buff_wr, output, 1 bit: one-cycle strobe qualifying sd_buff_dout.
REQ-014 SHALL have port img_mounted, output, 2 bits: one-cycle mount pulse per drive.
REQ-015 SHALL have port img_readonly, output, 2 bits: mirrors wp, registered.
REQ-016 SHALL have port img_size, output, 64 bits: the constant SECTORS*512.

Function
REQ-017 SHALL hold the image in internal byte RAM of 2*SECTORS*512 bytes, addressed as {drive, lba, byte}, with 1-cycle read latency; RAM contents SHALL NOT be altered by reset.
REQ-018 SHALL use states IDLE, MOUNT, DELAY, READ, WRITE and DONE.
REQ-019 MOUNT: on the first cycle after reset_n rises, pulse img_mounted=2'b11 for exactly 1 cycle, then go to IDLE.
REQ-020 IDLE: when (sd_rd|sd_wr)!=0, capture sd_lba, the drive and the direction, then go to DELAY.
REQ-021 Capture priority SHALL be sd_rd[0] > sd_rd[1] > sd_wr[0] > sd_wr[1].
REQ-022 DELAY: wait ACK_DLY cycles, then assert sd_ack, set byte counter=0, and enter READ or WRITE.
REQ-023 READ: for n=0..511, present sd_buff_addr=n and sd_buff_dout=RAM byte, with sd_buff_wr high for 1 cycle per byte.
REQ-024 READ pacing: one byte every 2 cycles, so 1024 cycles from the first strobe to the last strobe plus 2.
REQ-025 WRITE: for n=0..511, drive sd_buff_addr=n for 2 cycles and sample sd_buff_din on the second cycle (requester latency is 1 cycle).
REQ-026 WRITE: store the sampled byte at {drive, lba, n} unless wp[drive]=1, in which case bytes are consumed and discarded.
REQ-027 Out-of-range lba (lba >= SECTORS): the full handshake SHALL still run; reads return 8'hE5 for every byte and writes are discarded.
REQ-028 After byte 511, deassert sd_ack on the next cycle and enter DONE.
REQ-029 DONE: remain until the serviced request bit is 0, then go to IDLE; this prevents double service of a held request.
REQ-030 Requests arriving during DELAY, READ, WRITE or DONE SHALL be ignored until IDLE.
REQ-031 Changes to sd_lba after capture SHALL be ignored.
REQ-032 The byte counter SHALL be 9 bits; the terminal condition is count==511, with no wrap into a second sector.
REQ-033 img_readonly SHALL equal wp delayed by 1 cycle.
REQ-034 sd_buff_addr SHALL hold its last value outside a transfer.

Reset
REQ-035 reset_n=0 SHALL immediately force: state=MOUNT-pending, sd_ack=0, sd_buff_wr=0, sd_buff_addr=0, sd_buff_dout=0, img_mounted=0, img_readonly=0.
REQ-036 Reset mid-transfer SHALL abort the transfer with no further strobes or RAM writes; the next release performs MOUNT again.

Verification
REQ-037 Reset release -> img_mounted=2'b11 for exactly 1 cycle; img_size=4096.
REQ-038 Write drive 0 with lba=3, din=n^8'h5A, then read back -> 512 sd_buff_wr strobes; dout at addr n equals n[7:0]^8'h5A; sd_ack rises 2 cycles after request.
REQ-039 sd_rd=2'b11 and sd_wr=2'b01 together -> drive 0 read serviced first.
REQ-039 (cont.) Then drop sd_rd[0] -> drive 1 read serviced next.
REQ-040 wp=2'b10, write drive 1 lba=0 with 8'hFF, then read -> previous contents unchanged; img_readonly=2'b10.
REQ-041 Read lba=100 -> 512 bytes of 8'hE5 and normal ack timing.
REQ-042 Hold sd_rd[0] high after DONE -> no second transfer until it drops.
REQ-042 (cont.) Assert reset_n=0 at byte 200 -> sd_ack=0 at once and no strobes afterwards.
